// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundle of raster timing outputs from vga_timing_gen to the video path.
//   master : driven by the timing generator
//   slave  : consumed by colour / board-rendering / game logic
//   Signals:
//     pix_ce     - one-clk strobe at each pixel boundary
//     column     - visible x coordinate (0 outside visible area)
//     row        - visible y coordinate (0 outside visible area)
//     blank_n    - high only inside the visible area
//     hsync_n    - active-low horizontal sync
//     vsync_n    - active-low vertical sync
//     frame_tick - one-clk pulse on the first pixel after the visible area
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic       pix_ce;
    logic [9:0] column;
    logic [8:0] row;
    logic       blank_n;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_tick;

    modport master (
        output pix_ce,
        output column,
        output row,
        output blank_n,
        output hsync_n,
        output vsync_n,
        output frame_tick
    );

    modport slave (
        input pix_ce,
        input column,
        input row,
        input blank_n,
        input hsync_n,
        input vsync_n,
        input frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source: divides clk down to the pixel rate, runs the
//   horizontal/vertical counters and produces sync, blanking, visible-area
//   coordinates, a pixel strobe and a once-per-frame tick.
//
//   Ports:
//     clk - system clock
//     rst - synchronous, active-high reset
//     vga - vga_timing_gen_if.master (pix_ce, column, row, blank_n,
//           hsync_n, vsync_n, frame_tick)
//
//   Optional feature macro: VGA_SYNC_DELAY_EN
//     When defined, hsync_n / vsync_n / blank_n are delayed by two pixels
//     through a pix_ce-enabled shift register to line up with a registered
//     colour stage plus the DAC input register. row, column and frame_tick
//     are never delayed.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [3:0] r_div_cnt;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_started;
    logic       r_pix_ce;
    logic [9:0] r_column;
    logic [8:0] r_row;
    logic       r_blank_n;
    logic       r_hsync_n;
    logic       r_vsync_n;
    logic       r_frame_tick;

    logic [3:0] w_div_nxt;
    logic       w_pix_strobe;
    logic       w_advance;
    logic       w_line_end;
    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic       w_h_vis;
    logic       w_v_vis;

    // The strobe fires on the edge at which div_cnt enters CLK_DIV-1, so
    // pix_ce, the counters and every decoded output change on that same
    // edge. The very first strobe after reset only presents pixel (0,0);
    // the counters start advancing from the second strobe on.
    always_comb begin
        w_div_nxt    = (r_div_cnt == DIV_LAST) ? 4'd0 : r_div_cnt + 4'd1;
        w_pix_strobe = (w_div_nxt == DIV_LAST);
        w_advance    = w_pix_strobe && r_started;
        w_line_end   = (r_h_cnt == H_LAST);
        w_h_nxt      = r_h_cnt;
        w_v_nxt      = r_v_cnt;
        if (w_advance) begin
            if (w_line_end) begin
                w_h_nxt = 10'd0;
                w_v_nxt = (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                w_h_nxt = r_h_cnt + 10'd1;
            end
        end
        w_h_vis = (w_h_nxt < H_VIS_C);
        w_v_vis = (w_v_nxt < V_VIS_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= 4'd0;
            r_h_cnt      <= 10'd0;
            r_v_cnt      <= 10'd0;
            r_started    <= 1'b0;
            r_pix_ce     <= 1'b0;
            r_column     <= 10'd0;
            r_row        <= 9'd0;
            r_blank_n    <= 1'b0;
            r_hsync_n    <= 1'b1;
            r_vsync_n    <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_nxt;
            r_pix_ce     <= w_pix_strobe;
            r_frame_tick <= w_advance && (w_h_nxt == 10'd0) && (w_v_nxt == V_VIS_C);
            if (w_pix_strobe) begin
                r_started <= 1'b1;
                r_h_cnt   <= w_h_nxt;
                r_v_cnt   <= w_v_nxt;
                r_column  <= w_h_vis ? w_h_nxt : 10'd0;
                // v_cnt is wider than row, so clamp rather than truncate
                r_row     <= w_v_vis ? w_v_nxt[8:0] : 9'd0;
                r_blank_n <= w_h_vis && w_v_vis;
                r_hsync_n <= !((w_h_nxt >= H_SYNC_BEG) && (w_h_nxt < H_SYNC_END));
                r_vsync_n <= !((w_v_nxt >= V_SYNC_BEG) && (w_v_nxt < V_SYNC_END));
            end
        end
    end

    assign vga.pix_ce     = r_pix_ce;
    assign vga.column     = r_column;
    assign vga.row        = r_row;
    assign vga.frame_tick = r_frame_tick;

`ifdef VGA_SYNC_DELAY_EN
    // Stage [0] holds the previous pixel, stage [1] the one before that.
    logic [1:0] r_hs_dly;
    logic [1:0] r_vs_dly;
    logic [1:0] r_bl_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_dly <= 2'b11;
            r_vs_dly <= 2'b11;
            r_bl_dly <= 2'b00;
        end else if (w_pix_strobe) begin
            r_hs_dly <= {r_hs_dly[0], r_hsync_n};
            r_vs_dly <= {r_vs_dly[0], r_vsync_n};
            r_bl_dly <= {r_bl_dly[0], r_blank_n};
        end
    end

    assign vga.hsync_n = r_hs_dly[1];
    assign vga.vsync_n = r_vs_dly[1];
    assign vga.blank_n = r_bl_dly[1];
`else
    assign vga.hsync_n = r_hsync_n;
    assign vga.vsync_n = r_vsync_n;
    assign vga.blank_n = r_blank_n;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three generator instances run side by side:
//     0 "def" - default 640x480 timing, CLK_DIV=2
//     1 "sml" - reduced geometry (20x11 totals), CLK_DIV=3, used for
//               frame, coordinate-clamp and mid-frame reset behaviour
//     2 "d1"  - default horizontal timing, CLK_DIV=1, short frame
//   Expected outputs come from an arithmetic model of pixel position versus
//   clk cycles since reset release; they are queued at each clk edge and
//   compared half a cycle later.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_ce;
        logic [9:0] column;
        logic [8:0] row;
        logic       blank_n;
        logic       hsync_n;
        logic       vsync_n;
        logic       frame_tick;
    } out_t;

    localparam int NCYC = 3300;

    localparam int P_D  [3] = '{2, 3, 1};
    localparam int P_HV [3] = '{640, 12, 640};
    localparam int P_HF [3] = '{16, 2, 16};
    localparam int P_HS [3] = '{96, 3, 96};
    localparam int P_HB [3] = '{48, 3, 48};
    localparam int P_VV [3] = '{480, 6, 4};
    localparam int P_VF [3] = '{10, 1, 1};
    localparam int P_VS [3] = '{2, 2, 1};
    localparam int P_VB [3] = '{33, 2, 1};

`ifdef VGA_SYNC_DELAY_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic clk;
    logic rst_def;
    logic rst_sml;
    logic rst_d1;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sml ();
    vga_timing_gen_if if_d1 ();

    vga_timing_gen u_def (
        .clk (clk),
        .rst (rst_def),
        .vga (if_def)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VIS(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_sml (
        .clk (clk),
        .rst (rst_sml),
        .vga (if_sml)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_d1 (
        .clk (clk),
        .rst (rst_d1),
        .vga (if_d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    out_t q_exp [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected outputs of instance s, t clk edges after the last reset edge.
    function automatic out_t model(int s, int t);
        out_t o;
        int d, f, p, q, htot, vtot, h, v, hq, vq;
        o.pix_ce = 1'b0; o.column = 10'd0; o.row = 9'd0; o.blank_n = 1'b0;
        o.hsync_n = 1'b1; o.vsync_n = 1'b1; o.frame_tick = 1'b0;
        d = P_D[s];
        f = (d == 1) ? 1 : d - 1;        // edge index of the first pixel strobe
        if (t < f) return o;
        htot = P_HV[s] + P_HF[s] + P_HS[s] + P_HB[s];
        vtot = P_VV[s] + P_VF[s] + P_VS[s] + P_VB[s];
        p = (t - f) / d;
        h = p % htot;
        v = (p / htot) % vtot;
        o.pix_ce     = ((t - f) % d) == 0;
        o.column     = (h < P_HV[s]) ? 10'(h) : 10'd0;
        o.row        = (v < P_VV[s]) ? 9'(v) : 9'd0;
        o.frame_tick = o.pix_ce && (h == 0) && (v == P_VV[s]);
        q = p - LAG;
        if (q >= 0) begin
            hq = q % htot;
            vq = (q / htot) % vtot;
            o.blank_n = (hq < P_HV[s]) && (vq < P_VV[s]);
            o.hsync_n = !((hq >= P_HV[s] + P_HF[s]) && (hq < P_HV[s] + P_HF[s] + P_HS[s]));
            o.vsync_n = !((vq >= P_VV[s] + P_VF[s]) && (vq < P_VV[s] + P_VF[s] + P_VS[s]));
        end
        return o;
    endfunction

    function automatic out_t sample(int s);
        out_t o;
        case (s)
            0: o = {if_def.pix_ce, if_def.column, if_def.row, if_def.blank_n,
                    if_def.hsync_n, if_def.vsync_n, if_def.frame_tick};
            1: o = {if_sml.pix_ce, if_sml.column, if_sml.row, if_sml.blank_n,
                    if_sml.hsync_n, if_sml.vsync_n, if_sml.frame_tick};
            default: o = {if_d1.pix_ce, if_d1.column, if_d1.row, if_d1.blank_n,
                          if_d1.hsync_n, if_d1.vsync_n, if_d1.frame_tick};
        endcase
        return o;
    endfunction

    function automatic logic rst_of(int s);
        case (s)
            0:       return rst_def;
            1:       return rst_sml;
            default: return rst_d1;
        endcase
    endfunction

    string names [3] = '{"out_def", "out_sml", "out_d1"};

    initial begin
        int   t_i [3];
        out_t e_arr [3];
        out_t o_arr [3];
        out_t p_arr [3];
        int   mid_state;
        // default-instance measurements
        int hs_fall1, hs_fall2, hs_rise1, hs_fall1_t;
        int bl_rise, bl_fall, col_wrap_prev;
        // small-instance measurements
        int vs_fall1, vs_fall2, vs_rise1, ticks_pre, tick_post_t;
        // CLK_DIV=1 measurements
        int d1_fall1, d1_fall2;

        t_i = '{0, 0, 0};
        mid_state = 0;
        hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1; hs_fall1_t = -1;
        bl_rise = -1; bl_fall = -1; col_wrap_prev = -1;
        vs_fall1 = -1; vs_fall2 = -1; vs_rise1 = -1; ticks_pre = 0; tick_post_t = -1;
        d1_fall1 = -1; d1_fall2 = -1;

        rst_def = 1'b1;
        rst_sml = 1'b1;
        rst_d1  = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            for (int s = 0; s < 3; s++) begin
                if (rst_of(s)) t_i[s] = 0;
                else           t_i[s] = t_i[s] + 1;
                q_exp.push_back(model(s, t_i[s]));
            end

            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                p_arr[s] = o_arr[s];
                e_arr[s] = q_exp.pop_front();
                o_arr[s] = sample(s);
                check(names[s], 32'(o_arr[s]), 32'(e_arr[s]));
            end

            if (cyc > 0) begin
                // default instance: line timing and column wrap
                if (p_arr[0].hsync_n && !o_arr[0].hsync_n) begin
                    if (hs_fall1 < 0) begin
                        hs_fall1   = cyc;
                        hs_fall1_t = t_i[0];
                    end else if (hs_fall2 < 0) begin
                        hs_fall2 = cyc;
                    end
                end
                if (!p_arr[0].hsync_n && o_arr[0].hsync_n && hs_fall1 >= 0 && hs_rise1 < 0)
                    hs_rise1 = cyc;
                if (!p_arr[0].blank_n && o_arr[0].blank_n && bl_rise < 0) bl_rise = cyc;
                if (p_arr[0].blank_n && !o_arr[0].blank_n && bl_rise >= 0 && bl_fall < 0)
                    bl_fall = cyc;
                if (p_arr[0].column != 10'd0 && o_arr[0].column == 10'd0 && col_wrap_prev < 0)
                    col_wrap_prev = int'(p_arr[0].column);

                // small instance: frame timing and tick placement
                if (mid_state == 0) begin
                    if (p_arr[1].vsync_n && !o_arr[1].vsync_n) begin
                        if (vs_fall1 < 0)      vs_fall1 = cyc;
                        else if (vs_fall2 < 0) vs_fall2 = cyc;
                    end
                    if (!p_arr[1].vsync_n && o_arr[1].vsync_n && vs_fall1 >= 0 && vs_rise1 < 0)
                        vs_rise1 = cyc;
                end
                if (o_arr[1].frame_tick) begin
                    if (mid_state == 0)        ticks_pre++;
                    else if (tick_post_t < 0)  tick_post_t = t_i[1];
                end

                // CLK_DIV=1 instance: line period
                if (p_arr[2].hsync_n && !o_arr[2].hsync_n) begin
                    if (d1_fall1 < 0)      d1_fall1 = cyc;
                    else if (d1_fall2 < 0) d1_fall2 = cyc;
                end
            end

            // drive inputs for the next edge
            if (cyc == 2) begin
                rst_def = 1'b0;
                rst_sml = 1'b0;
                rst_d1  = 1'b0;
            end
            if (mid_state == 1) begin
                rst_sml   = 1'b0;
                mid_state = 2;
            end else if (mid_state == 0 && cyc > 1200 && e_arr[1].pix_ce &&
                         e_arr[1].row == 9'd4 && e_arr[1].column == 10'd5) begin
                rst_sml   = 1'b1;
                mid_state = 1;
            end
        end

        // default timing: 800 px x 2 clk per line, 96 px sync, 640 px visible
        check("hs_period_def",   32'(hs_fall2 - hs_fall1), 32'd1600);
        check("hs_low_def",      32'(hs_rise1 - hs_fall1), 32'd192);
        check("hs_first_t_def",  32'(hs_fall1_t),          32'(1 + (640 + 16 + LAG) * 2));
        check("blank_run_def",   32'(bl_fall - bl_rise),   32'd1280);
        check("col_last_def",    32'(col_wrap_prev),       32'd639);
        // small geometry: 20 px x 11 lines x 3 clk per frame, 2 sync lines
        check("vs_period_sml",   32'(vs_fall2 - vs_fall1), 32'd660);
        check("vs_low_sml",      32'(vs_rise1 - vs_fall1), 32'd120);
        check("ticks_pre_sml",   32'(ticks_pre),           32'd2);
        check("mid_rst_done",    32'(mid_state),           32'd2);
        check("tick_post_t_sml", 32'(tick_post_t),         32'(2 + 6 * 20 * 3));
        // CLK_DIV=1: one pixel per clk
        check("hs_period_d1",    32'(d1_fall2 - d1_fall1), 32'd800);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
